// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID/EX pipeline slice.
//   W_DEFAULT      default datapath width (matches registerFile)
//   REG_ADDR_W     register address width
//   PC_REG         architectural PC register, never bypassed or matched
//   CTRL_W_DEFAULT default width of the opaque decode control bundle
//   CNT_W_DEFAULT  default width of the bubble counter
//   byp_sel_e      operand source selection used by operand_bypass_mux
package pipeline_pkg;

  localparam int W_DEFAULT      = 16;
  localparam int REG_ADDR_W     = 4;
  localparam int CTRL_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT  = 16;

  localparam logic [REG_ADDR_W-1:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {
    BYP_RF  = 2'd0,
    BYP_EX  = 2'd1,
    BYP_MEM = 2'd2,
    BYP_WB  = 2'd3
  } byp_sel_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Resolves one source operand: picks the newest in-flight producer of src
// (EX, then MEM, then WB) over the stale register-file value. The PC
// register always comes from the register file.
// Ports:
//   src                     source register address
//   rf_val                  register-file read data for src
//   ex_en/ex_dst/ex_val     EX-stage producer (caller masks loads out of ex_en)
//   mem_en/mem_dst/mem_val  MEM-stage producer
//   wb_en/wb_dst/wb_val     write-back producer
//   operand                 resolved operand
module operand_bypass_mux
  import pipeline_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [W-1:0]          rf_val,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [W-1:0]          ex_val,
  input  logic                  mem_en,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [W-1:0]          mem_val,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic [W-1:0]          wb_val,
  output logic [W-1:0]          operand
);

  byp_sel_e sel_s;

  // Pick the youngest matching producer; a PC source short-circuits to the
  // register file, which also means a destination of PC can never match.
  always_comb begin
    sel_s = BYP_RF;
    if (src == PC_REG) begin
      sel_s = BYP_RF;
    end else if (ex_en && (ex_dst == src)) begin
      sel_s = BYP_EX;
    end else if (mem_en && (mem_dst == src)) begin
      sel_s = BYP_MEM;
    end else if (wb_en && (wb_dst == src)) begin
      sel_s = BYP_WB;
    end else begin
      sel_s = BYP_RF;
    end
  end

  // Operand data mux driven by the selection above.
  always_comb begin
    operand = rf_val;
    case (sel_s)
      BYP_RF:  operand = rf_val;
      BYP_EX:  operand = ex_val;
      BYP_MEM: operand = mem_val;
      BYP_WB:  operand = wb_val;
      default: operand = rf_val;
    endcase
  end

endmodule

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register. Captures register-file reads (with EX/MEM/WB
// bypass) and decode control, inserts a bubble on load-use hazards, honours
// downstream hold and branch flush, and counts load-use bubbles (saturating).
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   dec_*                           decoded instruction from IF/ID
//   rf_out0/1                       combinational register-file read data
//   ex_result                       ALU result of the instruction held in EX
//   mem_wr_en/mem_dst/mem_result    MEM-stage write-back candidate
//   wb_wr_en/wb_dst/wb_data         register-file write this cycle
//   hold, flush                     downstream freeze / branch kill
//   dec_stall                       upstream must re-present the same instruction
//   ex_*                            EX-stage register contents
//   bubble_cnt                      load-use bubble count, saturating
module decode_execute_stage
  import pipeline_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_src0,
  input  logic [REG_ADDR_W-1:0] dec_src1,
  input  logic                  dec_use0,
  input  logic                  dec_use1,
  input  logic [REG_ADDR_W-1:0] dec_dst,
  input  logic                  dec_wr_en,
  input  logic                  dec_is_load,
  input  logic [CTRL_W-1:0]     dec_ctrl,
  input  logic [W-1:0]          rf_out0,
  input  logic [W-1:0]          rf_out1,
  input  logic [W-1:0]          ex_result,
  input  logic                  mem_wr_en,
  input  logic [REG_ADDR_W-1:0] mem_dst,
  input  logic [W-1:0]          mem_result,
  input  logic                  wb_wr_en,
  input  logic [REG_ADDR_W-1:0] wb_dst,
  input  logic [W-1:0]          wb_data,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  dec_stall,
  output logic                  ex_valid,
  output logic [W-1:0]          ex_op0,
  output logic [W-1:0]          ex_op1,
  output logic [REG_ADDR_W-1:0] ex_dst,
  output logic                  ex_wr_en,
  output logic                  ex_is_load,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic                  ex_valid_r;
  logic [W-1:0]          ex_op0_r;
  logic [W-1:0]          ex_op1_r;
  logic [REG_ADDR_W-1:0] ex_dst_r;
  logic                  ex_wr_en_r;
  logic                  ex_is_load_r;
  logic [CTRL_W-1:0]     ex_ctrl_r;
  logic [CNT_W-1:0]      bubble_cnt_r;

  logic                  ex_byp_en_s;
  logic                  load_use_s;
  logic [W-1:0]          op0_s;
  logic [W-1:0]          op1_s;

  // A load's data is not available from EX, so only non-loads forward from there.
  assign ex_byp_en_s = ex_valid_r & ex_wr_en_r & ~ex_is_load_r;

  operand_bypass_mux #(.W(W)) u_byp0 (
    .src     (dec_src0),
    .rf_val  (rf_out0),
    .ex_en   (ex_byp_en_s),
    .ex_dst  (ex_dst_r),
    .ex_val  (ex_result),
    .mem_en  (mem_wr_en),
    .mem_dst (mem_dst),
    .mem_val (mem_result),
    .wb_en   (wb_wr_en),
    .wb_dst  (wb_dst),
    .wb_val  (wb_data),
    .operand (op0_s)
  );

  operand_bypass_mux #(.W(W)) u_byp1 (
    .src     (dec_src1),
    .rf_val  (rf_out1),
    .ex_en   (ex_byp_en_s),
    .ex_dst  (ex_dst_r),
    .ex_val  (ex_result),
    .mem_en  (mem_wr_en),
    .mem_dst (mem_dst),
    .mem_val (mem_result),
    .wb_en   (wb_wr_en),
    .wb_dst  (wb_dst),
    .wb_val  (wb_data),
    .operand (op1_s)
  );

  // Load-use hazard: decode reads a register the load in EX has not produced yet.
  always_comb begin
    load_use_s = 1'b0;
    if (dec_valid && ex_valid_r && ex_is_load_r && ex_wr_en_r && (ex_dst_r != PC_REG)) begin
      load_use_s = (dec_use0 && (dec_src0 == ex_dst_r)) ||
                   (dec_use1 && (dec_src1 == ex_dst_r));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // A flush kills the decode instruction, so a hazard on it need not stall.
  assign dec_stall = hold | (load_use_s & ~flush);

  // EX register and bubble counter: reset > flush > hold > load-use bubble > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_r   <= 1'b0;
      ex_op0_r     <= {W{1'b0}};
      ex_op1_r     <= {W{1'b0}};
      ex_dst_r     <= {REG_ADDR_W{1'b0}};
      ex_wr_en_r   <= 1'b0;
      ex_is_load_r <= 1'b0;
      ex_ctrl_r    <= {CTRL_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      ex_valid_r   <= 1'b0;
      ex_wr_en_r   <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (hold) begin
      // Frozen: operands keep their captured values, no re-resolve.
      ex_valid_r   <= ex_valid_r;
    end else if (load_use_s) begin
      ex_valid_r   <= 1'b0;
      ex_wr_en_r   <= 1'b0;
      ex_is_load_r <= 1'b0;
      if (bubble_cnt_r != {CNT_W{1'b1}}) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ex_valid_r   <= dec_valid;
      ex_op0_r     <= op0_s;
      ex_op1_r     <= op1_s;
      ex_dst_r     <= dec_dst;
      ex_wr_en_r   <= dec_valid & dec_wr_en;
      ex_is_load_r <= dec_valid & dec_is_load;
      ex_ctrl_r    <= dec_ctrl;
    end
  end

  assign ex_valid   = ex_valid_r;
  assign ex_op0     = ex_op0_r;
  assign ex_op1     = ex_op1_r;
  assign ex_dst     = ex_dst_r;
  assign ex_wr_en   = ex_wr_en_r;
  assign ex_is_load = ex_is_load_r;
  assign ex_ctrl    = ex_ctrl_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_decode_execute_stage.sv
module tb_decode_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic [3:0]  dec_src0, dec_src1, dec_dst;
  logic        dec_use0, dec_use1, dec_wr_en, dec_is_load;
  logic [7:0]  dec_ctrl;
  logic [15:0] rf_out0, rf_out1, ex_result, mem_result, wb_data;
  logic        mem_wr_en, wb_wr_en, hold, flush;
  logic [3:0]  mem_dst, wb_dst;
  logic        dec_stall, ex_valid, ex_wr_en, ex_is_load;
  logic [15:0] ex_op0, ex_op1;
  logic [3:0]  ex_dst;
  logic [7:0]  ex_ctrl;
  logic [3:0]  bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state (what the EX register should hold)
  logic        m_valid = 1'b0, m_wr = 1'b0, m_ld = 1'b0;
  logic [15:0] m_op0 = 16'h0, m_op1 = 16'h0;
  logic [3:0]  m_dst = 4'h0;
  logic [7:0]  m_ctrl = 8'h0;
  int          m_cnt = 0;

  decode_execute_stage #(.W(16), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src0(dec_src0), .dec_src1(dec_src1), .dec_use0(dec_use0), .dec_use1(dec_use1),
    .dec_dst(dec_dst), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .dec_ctrl(dec_ctrl),
    .rf_out0(rf_out0), .rf_out1(rf_out1), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_dst(mem_dst), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_dst(wb_dst), .wb_data(wb_data),
    .hold(hold), .flush(flush), .dec_stall(dec_stall),
    .ex_valid(ex_valid), .ex_op0(ex_op0), .ex_op1(ex_op1), .ex_dst(ex_dst),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Value a reader of src should see: the newest in-flight writer, else the register file.
  function automatic logic [15:0] ref_operand(input logic [3:0] src, input logic [15:0] rf);
    logic        pe [3];
    logic [3:0]  pd [3];
    logic [15:0] pv [3];
    pe[0] = m_valid && m_wr && !m_ld; pd[0] = m_dst;   pv[0] = ex_result;
    pe[1] = mem_wr_en;                pd[1] = mem_dst; pv[1] = mem_result;
    pe[2] = wb_wr_en;                 pd[2] = wb_dst;  pv[2] = wb_data;
    if (src == 4'd15) return rf;
    for (int i = 0; i < 3; i++) begin
      if (pe[i] && pd[i] == src) return pv[i];
    end
    return rf;
  endfunction

  function automatic logic ref_load_use();
    logic hit0, hit1;
    hit0 = dec_use0 && dec_src0 == m_dst;
    hit1 = dec_use1 && dec_src1 == m_dst;
    return dec_valid && m_valid && m_ld && m_wr && m_dst != 4'd15 && (hit0 || hit1);
  endfunction

  function automatic logic ref_stall();
    return hold || (ref_load_use() && !flush);
  endfunction

  // One clock edge: advance the model from the current inputs, then sample #1 after the edge.
  task automatic tick();
    logic        n_valid, n_wr, n_ld;
    logic [15:0] n_op0, n_op1;
    logic [3:0]  n_dst;
    logic [7:0]  n_ctrl;
    int          n_cnt;
    n_valid = m_valid; n_wr = m_wr; n_ld = m_ld; n_op0 = m_op0; n_op1 = m_op1;
    n_dst = m_dst; n_ctrl = m_ctrl; n_cnt = m_cnt;
    if (reset) begin
      n_valid = 0; n_wr = 0; n_ld = 0; n_op0 = 0; n_op1 = 0; n_dst = 0; n_ctrl = 0; n_cnt = 0;
    end else if (flush) begin
      n_valid = 0; n_wr = 0; n_ld = 0;
    end else if (hold) begin
      n_valid = m_valid;
    end else if (ref_load_use()) begin
      n_valid = 0; n_wr = 0; n_ld = 0;
      n_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
    end else begin
      n_valid = dec_valid;
      n_op0 = ref_operand(dec_src0, rf_out0);
      n_op1 = ref_operand(dec_src1, rf_out1);
      n_dst = dec_dst; n_ctrl = dec_ctrl;
      n_wr = dec_valid && dec_wr_en; n_ld = dec_valid && dec_is_load;
    end
    @(posedge clk); #1;
    m_valid = n_valid; m_wr = n_wr; m_ld = n_ld; m_op0 = n_op0; m_op1 = n_op1;
    m_dst = n_dst; m_ctrl = n_ctrl; m_cnt = n_cnt;
  endtask

  task automatic clear_inputs();
    reset = 0; dec_valid = 0; dec_src0 = 0; dec_src1 = 0; dec_use0 = 0; dec_use1 = 0;
    dec_dst = 0; dec_wr_en = 0; dec_is_load = 0; dec_ctrl = 0; rf_out0 = 0; rf_out1 = 0;
    ex_result = 0; mem_wr_en = 0; mem_dst = 0; mem_result = 0; wb_wr_en = 0; wb_dst = 0;
    wb_data = 0; hold = 0; flush = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1; dec_valid = 1; dec_src0 = 4'd1; dec_use0 = 1; rf_out0 = 16'h1234;
    dec_wr_en = 1; dec_ctrl = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
      vectors++; if (ex_op0 !== 16'h0 || ex_op1 !== 16'h0) begin miscompares++; $display("FAIL reset_ops got %h/%h exp 0/0", ex_op0, ex_op1); end
      vectors++; if (bubble_cnt !== 4'h0) begin miscompares++; $display("FAIL reset_cnt got %h exp 0", bubble_cnt); end
      vectors++; if (ex_wr_en !== 1'b0 || ex_ctrl !== 8'h0) begin miscompares++; $display("FAIL reset_ctrl got wr=%b ctrl=%h exp 0/00", ex_wr_en, ex_ctrl); end
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_bypass_priority();
    @(negedge clk);
    clear_inputs();
    dec_valid = 1; dec_dst = 4'd3; dec_wr_en = 1;
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_dst !== 4'd3) begin miscompares++; $display("FAIL byp_setup got v=%b dst=%0d exp 1/3", ex_valid, ex_dst); end
    @(negedge clk);
    dec_src0 = 4'd3; dec_use0 = 1; rf_out0 = 16'h1111; dec_dst = 4'd7;
    dec_src1 = 4'd2; dec_use1 = 1; rf_out1 = 16'h5555;
    wb_wr_en = 1; wb_dst = 4'd3; wb_data = 16'h3333;
    mem_wr_en = 1; mem_dst = 4'd3; mem_result = 16'h2222;
    ex_result = 16'h4444;
    tick();
    vectors++; if (ex_op0 !== 16'h4444) begin miscompares++; $display("FAIL byp_ex got %h exp 4444", ex_op0); end
    vectors++; if (ex_op1 !== 16'h5555) begin miscompares++; $display("FAIL byp_rf_op1 got %h exp 5555", ex_op1); end
    // EX now holds r7, so MEM is the newest writer of r3
    tick();
    vectors++; if (ex_op0 !== 16'h2222) begin miscompares++; $display("FAIL byp_mem got %h exp 2222", ex_op0); end
    @(negedge clk);
    mem_wr_en = 0;
    tick();
    vectors++; if (ex_op0 !== 16'h3333) begin miscompares++; $display("FAIL byp_wb got %h exp 3333", ex_op0); end
  endtask

  task automatic test_r15();
    @(negedge clk);
    clear_inputs();
    dec_valid = 1; dec_src1 = 4'd15; dec_use1 = 1; rf_out1 = 16'h0040;
    mem_wr_en = 1; mem_dst = 4'd15; mem_result = 16'hBEEF;
    wb_wr_en = 1; wb_dst = 4'd15; wb_data = 16'hCAFE;
    tick();
    vectors++; if (ex_op1 !== 16'h0040) begin miscompares++; $display("FAIL r15_pc got %h exp 0040", ex_op1); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    dec_valid = 1; dec_dst = 4'd5; dec_wr_en = 1; dec_is_load = 1;
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_is_load !== 1'b1) begin miscompares++; $display("FAIL lu_load got v=%b ld=%b exp 1/1", ex_valid, ex_is_load); end
    @(negedge clk);
    dec_is_load = 0; dec_dst = 4'd6; dec_src0 = 4'd5; dec_use0 = 1; rf_out0 = 16'h0001;
    #1;
    vectors++; if (dec_stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b exp 1", dec_stall); end
    tick();
    vectors++; if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got v=%b wr=%b exp 0/0", ex_valid, ex_wr_en); end
    vectors++; if (bubble_cnt !== 4'd1) begin miscompares++; $display("FAIL lu_cnt got %0d exp 1", bubble_cnt); end
    vectors++; if (dec_stall !== 1'b0) begin miscompares++; $display("FAIL lu_release got %b exp 0", dec_stall); end
    @(negedge clk);
    mem_wr_en = 1; mem_dst = 4'd5; mem_result = 16'h00AA;
    tick();
    vectors++; if (ex_op0 !== 16'h00AA || ex_valid !== 1'b1) begin miscompares++; $display("FAIL lu_fwd got op0=%h v=%b exp 00aa/1", ex_op0, ex_valid); end
  endtask

  task automatic test_flush_hold();
    @(negedge clk);
    clear_inputs();
    dec_valid = 1; dec_src0 = 4'd1; dec_use0 = 1; rf_out0 = 16'h1357; dec_dst = 4'd9;
    dec_wr_en = 1; dec_ctrl = 8'h5A;
    tick();
    @(negedge clk);
    hold = 1; flush = 1;
    tick();
    vectors++; if (ex_valid !== 1'b0 || ex_wr_en !== 1'b0) begin miscompares++; $display("FAIL flush_over_hold got v=%b wr=%b exp 0/0", ex_valid, ex_wr_en); end
    @(negedge clk);
    hold = 0; flush = 0;
    tick();
    vectors++; if (ex_valid !== 1'b1 || ex_op0 !== 16'h1357) begin miscompares++; $display("FAIL hold_setup got v=%b op0=%h exp 1/1357", ex_valid, ex_op0); end
    @(negedge clk);
    hold = 1; dec_dst = 4'd2; dec_ctrl = 8'h33; rf_out0 = 16'hFFFF;
    mem_wr_en = 1; mem_dst = 4'd1; mem_result = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (dec_stall !== 1'b1) begin miscompares++; $display("FAIL hold_stall cyc%0d got %b exp 1", i, dec_stall); end
      tick();
      vectors++; if (ex_valid !== 1'b1 || ex_op0 !== 16'h1357 || ex_ctrl !== 8'h5A || ex_dst !== 4'd9)
        begin miscompares++; $display("FAIL hold_frozen cyc%0d got v=%b op0=%h ctrl=%h dst=%0d exp 1/1357/5a/9", i, ex_valid, ex_op0, ex_ctrl, ex_dst); end
    end
    @(negedge clk);
    hold = 0;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    @(negedge clk);
    clear_inputs();
    exp_cnt = int'(bubble_cnt);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      dec_valid = 1; dec_dst = 4'd4; dec_wr_en = 1; dec_is_load = 1; dec_use0 = 0; dec_src0 = 4'd0;
      tick();
      @(negedge clk);
      dec_is_load = 0; dec_dst = 4'd8; dec_src0 = 4'd4; dec_use0 = 1;
      tick();
      exp_cnt = (exp_cnt + 1 > 15) ? 15 : exp_cnt + 1;
      vectors++; if (bubble_cnt !== exp_cnt[3:0]) begin miscompares++; $display("FAIL sat_step%0d got %0d exp %0d", i, bubble_cnt, exp_cnt); end
    end
    vectors++; if (bubble_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_final got %h exp f", bubble_cnt); end
  endtask

  function automatic logic [3:0] rnd_reg();
    int a;
    a = $urandom_range(0, 4);
    return (a == 4) ? 4'd15 : 4'(a);
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 5) == 0);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_src0 = rnd_reg(); dec_src1 = rnd_reg(); dec_dst = rnd_reg();
      dec_use0 = 1'($urandom); dec_use1 = 1'($urandom);
      dec_wr_en = 1'($urandom); dec_is_load = ($urandom_range(0, 2) == 0);
      dec_ctrl = 8'($urandom); rf_out0 = 16'($urandom); rf_out1 = 16'($urandom);
      ex_result = 16'($urandom); mem_result = 16'($urandom); wb_data = 16'($urandom);
      mem_wr_en = 1'($urandom); mem_dst = rnd_reg(); wb_wr_en = 1'($urandom); wb_dst = rnd_reg();
      #1;
      vectors++; if (dec_stall !== ref_stall()) begin miscompares++; $display("FAIL rnd_stall it%0d got %b exp %b", i, dec_stall, ref_stall()); end
      tick();
      vectors++; if (ex_valid !== m_valid || ex_wr_en !== m_wr || ex_is_load !== m_ld)
        begin miscompares++; $display("FAIL rnd_flags it%0d got v=%b wr=%b ld=%b exp %b/%b/%b", i, ex_valid, ex_wr_en, ex_is_load, m_valid, m_wr, m_ld); end
      vectors++; if (bubble_cnt !== m_cnt[3:0]) begin miscompares++; $display("FAIL rnd_cnt it%0d got %0d exp %0d", i, bubble_cnt, m_cnt); end
      if (m_valid) begin
        vectors++; if (ex_op0 !== m_op0 || ex_op1 !== m_op1 || ex_dst !== m_dst || ex_ctrl !== m_ctrl)
          begin miscompares++; $display("FAIL rnd_data it%0d got %h/%h/%0d/%h exp %h/%h/%0d/%h", i, ex_op0, ex_op1, ex_dst, ex_ctrl, m_op0, m_op1, m_dst, m_ctrl); end
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_bypass_priority();
    test_r15();
    test_load_use();
    test_flush_hold();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
